// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame parser.
// Optional ACK/NAK generation is enabled by the macro UART_CMD_ACK_EN.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    S_CMD,
    S_X,
    S_Y,
    S_CHK
  } state_t;

  localparam logic [1:0] ERR_CHK   = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

  localparam logic [7:0] ACK_OK   = 8'h55;
  localparam logic [7:0] NAK_BASE = 8'hE0;

  function automatic logic [7:0] frame_chk(input logic [7:0] c,
                                           input logic [7:0] x,
                                           input logic [7:0] y);
    return c ^ x ^ y;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-in / frame-out bundle between UART receiver, parser and game logic.
// ack_data/ack_start exist only when UART_CMD_ACK_EN is defined.
interface uart_cmd_parser_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] cmd;
  logic [3:0] x;
  logic [3:0] y;
  logic       frame_valid;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;
`ifdef UART_CMD_ACK_EN
  logic [7:0] ack_data;
  logic       ack_start;
`endif

  // master: the parser itself
  modport master (
    input  rx_data, rx_done,
    output cmd, x, y, frame_valid, frame_err, err_code, busy
`ifdef UART_CMD_ACK_EN
    , output ack_data, ack_start
`endif
  );

  // slave: UART receiver feeding bytes plus the game logic consuming frames
  modport slave (
    output rx_data, rx_done,
    input  cmd, x, y, frame_valid, frame_err, err_code, busy
`ifdef UART_CMD_ACK_EN
    , input ack_data, ack_start
`endif
  );
endinterface

// File: rtl/uart_cmd_timeout.sv
// Inter-byte gap watchdog: clears on every byte, counts while enabled and
// flags expiry on the cycle the count reaches TIMEOUT_CYC-1 with no byte.
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYC = 1000000,
  parameter int CNT_W       = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // a byte on the expiry cycle wins, so clr masks expire
  assign expire = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   cnt <= '0;
    else if (clr || !en || expire) cnt <= '0;
    else                          cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles SYNC/CMD/X/Y/CHK frames from UART bytes, validates checksum and
// board range, and reports timeouts. UART_CMD_ACK_EN adds an ACK/NAK byte.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = 8'hAA,
  parameter int         BOARD_SIZE  = 15,
  parameter int         TIMEOUT_CYC = 1000000,
  parameter int         CNT_W       = 20
) (
  input logic               clk,
  input logic               reset,
  uart_cmd_parser_if.master bus
);

  state_t     state;
  logic [7:0] cmd_r, x_r, y_r;
  logic       in_frame;
  logic       tmo;
  logic       chk_ok;
  logic       range_ok;

  assign in_frame = (state != IDLE);
  assign bus.busy = in_frame;

  uart_cmd_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .clr    (bus.rx_done),
    .en     (in_frame),
    .expire (tmo)
  );

  // evaluated against the byte arriving in S_CHK
  assign chk_ok   = (frame_chk(cmd_r, x_r, y_r) == bus.rx_data);
  assign range_ok = (x_r < 8'(BOARD_SIZE)) && (y_r < 8'(BOARD_SIZE));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      cmd_r           <= '0;
      x_r             <= '0;
      y_r             <= '0;
      bus.cmd         <= '0;
      bus.x           <= '0;
      bus.y           <= '0;
      bus.frame_valid <= 1'b0;
      bus.frame_err   <= 1'b0;
      bus.err_code    <= '0;
    end else begin
      bus.frame_valid <= 1'b0;
      bus.frame_err   <= 1'b0;
      if (tmo) begin
        state         <= IDLE;
        bus.frame_err <= 1'b1;
        bus.err_code  <= ERR_TMO;
      end else if (bus.rx_done) begin
        // no resync: SYNC_BYTE inside a frame is plain data
        case (state)
          IDLE:  if (bus.rx_data == SYNC_BYTE) state <= S_CMD;
          S_CMD: begin cmd_r <= bus.rx_data; state <= S_X;   end
          S_X:   begin x_r   <= bus.rx_data; state <= S_Y;   end
          S_Y:   begin y_r   <= bus.rx_data; state <= S_CHK; end
          S_CHK: begin
            state <= IDLE;
            if (!chk_ok) begin
              bus.frame_err <= 1'b1;
              bus.err_code  <= ERR_CHK;
            end else if (!range_ok) begin
              bus.frame_err <= 1'b1;
              bus.err_code  <= ERR_RANGE;
            end else begin
              bus.frame_valid <= 1'b1;
              bus.cmd         <= cmd_r;
              bus.x           <= x_r[3:0];
              bus.y           <= y_r[3:0];
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef UART_CMD_ACK_EN
  // one stage behind the result pulses; err_code is already settled here
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.ack_data  <= '0;
      bus.ack_start <= 1'b0;
    end else begin
      bus.ack_start <= bus.frame_valid || bus.frame_err;
      if (bus.frame_valid)    bus.ack_data <= ACK_OK;
      else if (bus.frame_err) bus.ack_data <= NAK_BASE | {6'b0, bus.err_code};
    end
  end
`endif

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Byte-level command-frame decoder on the receive side of the board's UART link. Consumes the byte strobe and data from the UART receiver and assembles 5-byte move/command frames sent by the host PC. Delivers validated (cmd, x, y) to the game logic, and reports checksum, range and timeout errors. Sits between the UART receiver output and the game controller; optionally produces an ACK/NAK byte for the UART transmitter.

Parameters:
SYNC_BYTE, 8'hAA, frame start marker
BOARD_SIZE, 15, legal coordinate range is 0..BOARD_SIZE-1
TIMEOUT_CYC, 1000000, maximum inter-byte gap in clk cycles (10 ms at 100 MHz)
CNT_W, 20, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYC

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset (0 = reset)
rx_data  input  8  received byte, valid when rx_done=1
rx_done  input  1  one-cycle byte strobe
cmd  output  8  command byte of last valid frame
x  output  4  column of last valid frame
y  output  4  row of last valid frame
frame_valid  output  1  one-cycle pulse: new cmd/x/y
frame_err  output  1  one-cycle pulse: frame rejected
err_code  output  2  01 checksum, 10 range, 11 timeout; held until next frame_err
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset asserted: state IDLE. All outputs 0. Timeout counter 0. Applies immediately, including mid-frame.
- Frame format: SYNC, CMD, X, Y, CHK, where CHK = CMD ^ X ^ Y (8-bit XOR).
- A byte is accepted on any rising clk edge where rx_done=1. rx_done is a single-cycle strobe; each high cycle counts as one byte.
- FSM states and transitions on an accepted byte:
  - IDLE -> S_CMD only if rx_data == SYNC_BYTE. Other bytes are ignored silently.
  - S_CMD -> S_X: latch cmd_r.
  - S_X -> S_Y: latch x_r (full 8 bits).
  - S_Y -> S_CHK: latch y_r.
  - S_CHK -> IDLE: evaluate the frame.
- No resync inside a frame: SYNC_BYTE received in S_CMD..S_CHK is treated as ordinary data.
- Frame evaluation, in priority order:
  1. Checksum mismatch -> err 01.
  2. Else x_r >= BOARD_SIZE or y_r >= BOARD_SIZE -> err 10.
  3. Else valid frame.
- Result latency: frame_valid or frame_err pulses exactly 1 cycle after the CHK byte is accepted. cmd/x/y (x, y = low 4 bits) update in the same cycle as frame_valid and hold until the next valid frame. A rejected frame leaves cmd/x/y unchanged.
- Timeout:
  - The counter clears on every accepted byte and increments each cycle while state != IDLE.
  - When the count reaches TIMEOUT_CYC-1 with no byte that cycle: go to IDLE, pulse frame_err with err_code 11 on the next cycle.
  - An accepted byte in the same cycle as expiry wins: no timeout, counter clears.
  - The counter does not run in IDLE.
- frame_valid and frame_err are never high in the same cycle.
- busy is combinational from the state register.

Optional Feature:
Macro UART_CMD_ACK_EN.
- When defined, add outputs ack_data[7:0] and ack_start (1-cycle pulse), registered and reset to 0.
- ack_start pulses 1 cycle after frame_valid or frame_err, i.e. 2 cycles after the CHK byte.
- ack_data values: 8'h55 for a valid frame; 8'hE0 | err_code for errors, including timeout.
- ack_data holds until the next ack.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package uart_cmd_pkg holds:
  - state encoding constants (IDLE, S_CMD, S_X, S_Y, S_CHK)
  - err_code constants (ERR_CHK=2'b01, ERR_RANGE=2'b10, ERR_TMO=2'b11)
  - ACK_OK=8'h55, NAK_BASE=8'hE0
- One natural sub-module, uart_cmd_timeout: the clear/enable/expire counter parameterised by TIMEOUT_CYC and CNT_W.
- FSM and checksum stay in the top.

Test Plan:
- Bytes AA 01 07 07 01 (one strobe every 16 cycles) -> frame_valid 1 cycle after last strobe; cmd=01, x=7, y=7; frame_err never set.
- Bytes AA 02 03 04 00 -> frame_err, err_code=01; cmd/x/y keep previous values (01/7/7).
- Bytes AA 01 0F 02 0C (checksum correct, x=15) -> frame_err, err_code=10.
- Bytes 13 55 AA 02 0E 00 0C (garbage before sync) -> frame_valid; cmd=02, x=14, y=0.
- Bytes AA 01 then silence -> busy drops and frame_err with err_code=11 exactly TIMEOUT_CYC (+1) cycles after the 01 strobe; a byte landing on the expiry cycle instead continues the frame.
- Reset low after AA 01 05 -> outputs 0, state IDLE. Then AA 03 04 05 02 -> valid cmd=03, x=4, y=5. With UART_CMD_ACK_EN: ack_data=55, ack_start 2 cycles after CHK.
